// File: rtl/mips_pkg.sv
// Shared opcode/funct constants, FSM state encoding and control codes
// for the multi-cycle MIPS-subset controller.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b100
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_LUI = 2'b10
    } wb_sel_e;

    typedef enum logic [1:0] {
        PC_SEQ = 2'b00,
        PC_BR  = 2'b01,
        PC_JMP = 2'b10
    } pc_src_e;

    typedef enum logic [2:0] {
        CL_ALU_R,
        CL_ALU_I,
        CL_LUI,
        CL_LW,
        CL_SW,
        CL_BEQ,
        CL_J,
        CL_ILL
    } iclass_e;

    typedef struct packed {
        iclass_e cls;
        alu_op_e alu_op;
        logic    ext_op;
        logic    dst_rd;
    } dec_t;

    // Classes whose second ALU operand is the extended immediate
    function automatic logic uses_imm(iclass_e c);
        return (c == CL_ALU_I) || (c == CL_LUI) ||
               (c == CL_LW)    || (c == CL_SW);
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: class, ALU operation,
// extension mode and destination-field select.
module mc_decode
    import mips_pkg::*;
(
    input  logic [31:0] instr_i,
    output dec_t        dec_o
);

    logic [5:0] op;
    logic [5:0] fn;
    logic       unused_fields;

    assign op = instr_i[31:26];
    assign fn = instr_i[5:0];
    assign unused_fields = ^instr_i[25:6];

    always_comb begin
        dec_o.cls    = CL_ILL;
        dec_o.alu_op = ALU_ADD;
        dec_o.ext_op = 1'b1;
        dec_o.dst_rd = 1'b0;
        case (op)
            OP_RTYPE: begin
                dec_o.cls    = CL_ALU_R;
                dec_o.dst_rd = 1'b1;
                case (fn)
                    FN_ADDU: dec_o.alu_op = ALU_ADD;
                    FN_SUBU: dec_o.alu_op = ALU_SUB;
                    FN_AND:  dec_o.alu_op = ALU_AND;
                    FN_OR:   dec_o.alu_op = ALU_OR;
                    FN_SLT:  dec_o.alu_op = ALU_SLT;
                    default: dec_o.cls    = CL_ILL;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                dec_o.cls = CL_ALU_I;
            end
            OP_ANDI: begin
                dec_o.cls    = CL_ALU_I;
                dec_o.alu_op = ALU_AND;
                dec_o.ext_op = 1'b0;
            end
            OP_ORI: begin
                dec_o.cls    = CL_ALU_I;
                dec_o.alu_op = ALU_OR;
                dec_o.ext_op = 1'b0;
            end
            OP_LUI: begin
                dec_o.cls    = CL_LUI;
                dec_o.ext_op = 1'b0;
            end
            OP_LW:  dec_o.cls = CL_LW;
            OP_SW:  dec_o.cls = CL_SW;
            OP_BEQ: begin
                dec_o.cls    = CL_BEQ;
                dec_o.alu_op = ALU_SUB;
            end
            OP_J:   dec_o.cls = CL_J;
            default: dec_o.cls = CL_ILL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle controller FSM: FETCH/DECODE/EXEC/MEM/WB/HALT with
// Moore outputs decoded from state plus the held instruction.
module mc_ctrl
    import mips_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        ir_write,
    output logic        reg_write,
    output logic [4:0]  num_write,
    output logic [1:0]  wb_sel,
    output logic        alu_src,
    output logic [2:0]  alu_op,
    output logic        ext_op,
    output logic        mem_write,
    output logic        illegal
);

    dec_t   dec;
    state_e state_q, state_d;
    logic   illegal_q, illegal_d;

    mc_decode u_decode (
        .instr_i (instr),
        .dec_o   (dec)
    );

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        unique case (state_q)
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                if (dec.cls == CL_J) begin
                    state_d = ST_FETCH;
                end else if (dec.cls == CL_ILL) begin
                    state_d   = ST_HALT;
                    illegal_d = 1'b1;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (dec.cls == CL_BEQ) begin
                    state_d = ST_FETCH;
                end else if (dec.cls == CL_LW || dec.cls == CL_SW) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                state_d = (dec.cls == CL_LW) ? ST_WB : ST_FETCH;
            end
            ST_WB:   state_d = ST_FETCH;
            ST_HALT: begin
                state_d   = ST_HALT;
                illegal_d = 1'b1;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        pc_write  = 1'b0;
        pc_src    = PC_SEQ;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        num_write = 5'd0;
        wb_sel    = WB_ALU;
        alu_src   = 1'b0;
        mem_write = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
            end
            ST_DECODE: begin
                if (dec.cls == CL_J) begin
                    pc_write = 1'b1;
                    pc_src   = PC_JMP;
                end
            end
            ST_EXEC: begin
                alu_src = uses_imm(dec.cls);
                // Branch resolution is the one Mealy term: it follows zero
                if (dec.cls == CL_BEQ) begin
                    pc_write = zero;
                    pc_src   = PC_BR;
                end
            end
            ST_MEM: begin
                mem_write = (dec.cls == CL_SW);
            end
            ST_WB: begin
                reg_write = 1'b1;
                num_write = dec.dst_rd ? instr[15:11] : instr[20:16];
                if (dec.cls == CL_LW) begin
                    wb_sel = WB_MEM;
                end else if (dec.cls == CL_LUI) begin
                    wb_sel = WB_LUI;
                end else begin
                    wb_sel = WB_ALU;
                end
            end
            default: ;
        endcase
        // Reset state is FETCH, so its enables must be masked while held
        if (!reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            num_write = 5'd0;
            alu_src   = 1'b0;
            mem_write = 1'b0;
        end
    end

    assign alu_op  = dec.alu_op;
    assign ext_op  = dec.ext_op;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed cases plus random instruction
// streams compared against a per-cycle expectation model.
module tb_mc_ctrl;

    logic        clock;
    logic        reset;
    logic [31:0] instr;
    logic        zero;
    logic        pc_write, ir_write, reg_write, alu_src;
    logic        ext_op, mem_write, illegal;
    logic [1:0]  pc_src, wb_sel;
    logic [4:0]  num_write;
    logic [2:0]  alu_op;

    int total;
    int bad;

    mc_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .instr     (instr),
        .zero      (zero),
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .ir_write  (ir_write),
        .reg_write (reg_write),
        .num_write (num_write),
        .wb_sel    (wb_sel),
        .alu_src   (alu_src),
        .alu_op    (alu_op),
        .ext_op    (ext_op),
        .mem_write (mem_write),
        .illegal   (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam int K_R   = 0;
    localparam int K_I   = 1;
    localparam int K_LUI = 2;
    localparam int K_LW  = 3;
    localparam int K_SW  = 4;
    localparam int K_BEQ = 5;
    localparam int K_J   = 6;
    localparam int K_ILL = 7;

    // {pc_write, pc_src, ir_write, reg_write, num_write, wb_sel,
    //  alu_src, mem_write, illegal}
    logic [14:0] obs;
    assign obs = {pc_write, pc_src, ir_write, reg_write, num_write,
                  wb_sel, alu_src, mem_write, illegal};

    localparam logic [14:0] M_BASE = 15'b1_00_1_1_11111_00_0_1_1;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         kind;
        logic [2:0] aop;
        logic       ext;
        bit         has_aop;
    } ent_t;

    ent_t tab [16];

    function automatic ent_t ent(input logic [5:0] op, input logic [5:0] fn,
                                 input int kind, input logic [2:0] aop,
                                 input logic ext, input bit ha);
        ent_t e;
        e.op = op; e.fn = fn; e.kind = kind;
        e.aop = aop; e.ext = ext; e.has_aop = ha;
        return e;
    endfunction

    function automatic int lat(input int kind);
        if (kind == K_J)   return 2;
        if (kind == K_BEQ) return 3;
        if (kind == K_LW)  return 5;
        return 4;
    endfunction

    function automatic int wb_cycle(input int kind);
        if (kind == K_R || kind == K_I || kind == K_LUI) return 4;
        if (kind == K_LW) return 5;
        return 0;
    endfunction

    // Expected outputs in cycle c (1 = FETCH) of one instruction
    function automatic logic [14:0] exp_vec(input int kind,
                                            input logic [31:0] ins,
                                            input int c, input logic z,
                                            output logic [14:0] m);
        logic [14:0] e;
        e = '0;
        m = M_BASE;
        if (c == 1) begin
            e[14] = 1'b1;
            e[11] = 1'b1;
            m[13:12] = 2'b11;
        end
        if (kind == K_J && c == 2) begin
            e[14] = 1'b1;
            e[13:12] = 2'b10;
            m[13:12] = 2'b11;
        end
        if (c == 3 && kind != K_J && kind != K_ILL) begin
            m[2] = 1'b1;
            e[2] = (kind == K_I || kind == K_LUI ||
                    kind == K_LW || kind == K_SW);
        end
        if (kind == K_BEQ && c == 3) begin
            e[14] = z;
            e[13:12] = 2'b01;
            m[13:12] = 2'b11;
        end
        if (kind == K_SW && c == 4) e[1] = 1'b1;
        if (c == wb_cycle(kind)) begin
            e[10] = 1'b1;
            e[9:5] = (kind == K_R) ? ins[15:11] : ins[20:16];
            m[4:3] = 2'b11;
            e[4:3] = (kind == K_LW) ? 2'b01 : (kind == K_LUI) ? 2'b10 : 2'b00;
        end
        if (kind == K_ILL) begin
            if (c == 2) m[0] = 1'b0;
            if (c >= 3) e[0] = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [31:0] gen(input int idx);
        logic [31:0] r;
        r = $urandom;
        r[31:26] = tab[idx].op;
        if (tab[idx].op == 6'h00) begin
            r[5:0] = tab[idx].fn;
            r[10:6] = 5'd0;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] x);
        total++;
        assert (o === x) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, x);
        end
    endtask

    // Starts at FETCH (just after an edge); returns just after the edge
    // ending the last cycle run. ncyc=0 runs the full instruction.
    task automatic run(input logic [31:0] ins, input int idx,
                       input string tag, input int zmode, input int ncyc);
        int k;
        int n;
        logic [14:0] e, m;
        k = tab[idx].kind;
        n = (ncyc > 0) ? ncyc : lat(k);
        for (int c = 1; c <= n; c++) begin
            if (c == 1) instr = ins;
            zero = (zmode < 0) ? ($urandom_range(0, 1) == 1) : (zmode == 1);
            #1;
            e = exp_vec(k, ins, c, zero, m);
            chk($sformatf("%s c%0d outs", tag, c),
                32'(obs & m), 32'(e & m));
            if (c >= 2 && k != K_J && k != K_ILL) begin
                if (tab[idx].has_aop)
                    chk($sformatf("%s c%0d alu_op", tag, c),
                        32'(alu_op), 32'(tab[idx].aop));
                chk($sformatf("%s c%0d ext_op", tag, c),
                    32'(ext_op), 32'(tab[idx].ext));
            end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1'b0;
        #1;
        chk({tag, " rst now"}, 32'(obs & M_BASE), 32'd0);
        @(posedge clock);
        #1;
        chk({tag, " rst held"}, 32'(obs & M_BASE), 32'd0);
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] ins;
        logic [14:0] e, m;
        int idx;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        instr = 32'd0;
        zero  = 1'b0;

        tab[0]  = ent(6'h00, 6'h21, K_R,   3'd0, 1'b1, 1'b1);
        tab[1]  = ent(6'h00, 6'h23, K_R,   3'd1, 1'b1, 1'b1);
        tab[2]  = ent(6'h00, 6'h24, K_R,   3'd2, 1'b1, 1'b1);
        tab[3]  = ent(6'h00, 6'h25, K_R,   3'd3, 1'b1, 1'b1);
        tab[4]  = ent(6'h00, 6'h2A, K_R,   3'd4, 1'b1, 1'b1);
        tab[5]  = ent(6'h08, 6'h00, K_I,   3'd0, 1'b1, 1'b1);
        tab[6]  = ent(6'h09, 6'h00, K_I,   3'd0, 1'b1, 1'b1);
        tab[7]  = ent(6'h0C, 6'h00, K_I,   3'd2, 1'b0, 1'b1);
        tab[8]  = ent(6'h0D, 6'h00, K_I,   3'd3, 1'b0, 1'b1);
        tab[9]  = ent(6'h0F, 6'h00, K_LUI, 3'd0, 1'b0, 1'b0);
        tab[10] = ent(6'h23, 6'h00, K_LW,  3'd0, 1'b1, 1'b1);
        tab[11] = ent(6'h2B, 6'h00, K_SW,  3'd0, 1'b1, 1'b1);
        tab[12] = ent(6'h04, 6'h00, K_BEQ, 3'd1, 1'b1, 1'b1);
        tab[13] = ent(6'h02, 6'h00, K_J,   3'd0, 1'b1, 1'b0);
        tab[14] = ent(6'h3F, 6'h00, K_ILL, 3'd0, 1'b1, 1'b0);
        tab[15] = ent(6'h00, 6'h20, K_ILL, 3'd0, 1'b1, 1'b0);

        #3;
        reset = 1'b0;
        #1;
        chk("reset outs", 32'(obs & M_BASE), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        chk("reset held outs", 32'(obs & M_BASE), 32'd0);
        reset = 1'b1;

        run(32'h00221821, 0,  "addu",    -1, 0);
        run(32'h8C050004, 10, "lw",      -1, 0);
        run(32'h10210002, 12, "beq z1",   1, 0);
        run(32'h10210002, 12, "beq z0",   0, 0);
        run(32'h08000C00, 13, "j",       -1, 0);
        run(32'h00220021, 0,  "addu r0", -1, 0);
        run(gen(11),      11, "sw",      -1, 0);
        run(gen(9),       9,  "lui",     -1, 0);

        for (int n = 0; n < 300; n++) begin
            idx = $urandom_range(0, 13);
            run(gen(idx), idx, $sformatf("rnd%0d", n), -1, 0);
        end

        ins = gen(8);
        run(ins, 8, "ori abort", -1, 3);
        zero = 1'b0;
        #1;
        e = exp_vec(K_I, ins, 4, 1'b0, m);
        chk("ori wb before rst", 32'(obs & m), 32'(e & m));
        pulse_reset("ori");
        run(gen(0), 0, "after ori rst", -1, 0);
        run(gen(10), 10, "after ori rst2", -1, 0);

        run(32'hFC000000, 14, "halt 3f", -1, 22);
        pulse_reset("halt 3f");
        run(32'h00221821, 0, "after halt", -1, 0);

        run(gen(15), 15, "halt add", -1, 8);
        pulse_reset("halt add");
        run(gen(12), 12, "after halt2", -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have port: clock  in  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port: instr  in  32  current instruction register contents, held stable by the datapath between ir_write pulses.
REQ-004 SHALL have port: zero  in  1  ALU equality flag, valid during EXEC.
REQ-005 SHALL have port: pc_write  out  1  PC load enable.
REQ-006 SHALL have port: pc_src  out  2  PC source select: 00 pc+4, 01 branch target, 10 jump target.
REQ-007 SHALL have port: ir_write  out  1  instruction register load enable.
REQ-008 SHALL have ports: reg_write  out  1; num_write  out  5; together these form the register-file write port control.
REQ-009 SHALL have port: wb_sel  out  2  write-back select: 00 ALU result, 01 memory data, 10 lui immediate.
REQ-010 SHALL have ports: alu_src  out  1 (1 selects the extended immediate); alu_op  out  3; ext_op  out  1 (1 selects sign extension).
REQ-011 SHALL have port: mem_write  out  1  data memory write enable.
REQ-012 SHALL have port: illegal  out  1  sticky flag for an unsupported instruction.

Function
REQ-013 SHALL implement the FSM states FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-014 FETCH SHALL assert ir_write=1, pc_write=1 and pc_src=00, then go to DECODE.
REQ-015 DECODE SHALL classify instr[31:26]/[5:0] and act as follows: j sets pc_write=1 and pc_src=10, then goes to FETCH; unsupported instructions go to HALT; all other instructions go to EXEC.
REQ-016 Supported instructions SHALL be: R-type addu, subu, and, or, slt; I-type addi, addiu, andi, ori, lui; lw; sw; beq; j.
REQ-017 alu_op SHALL be encoded as: 000 add, 001 sub, 010 and, 011 or, 100 slt.
REQ-018 alu_op SHALL use: add for addi/addiu/lw/sw, sub for beq, and for andi, or for ori.
REQ-019 ext_op SHALL be 0 for andi/ori/lui and 1 otherwise.
REQ-020 EXEC SHALL assert alu_src=1 for I-type, lw and sw.
REQ-021 For beq, EXEC SHALL set pc_write=zero and pc_src=01, then go to FETCH.
REQ-022 From EXEC, lw and sw SHALL go to MEM; all other instructions SHALL go to WB.
REQ-023 MEM SHALL assert mem_write=1 for sw and then go to FETCH; for lw it SHALL go to WB.
REQ-024 WB SHALL assert reg_write=1 for exactly one cycle, then go to FETCH.
REQ-025 In WB, num_write SHALL be instr[15:11] for R-type and instr[20:16] otherwise; wb_sel SHALL be 01 for lw, 10 for lui and 00 otherwise.
REQ-026 Writes to register 0 SHALL still be issued; the register file discards them.
REQ-027 Instruction latency SHALL be: j 2 cycles, beq 3, sw 4, ALU-type 4, lw 5.
REQ-028 All enables SHALL be 0 in any state not named above; num_write SHALL be 0 outside WB.
REQ-029 HALT SHALL set illegal=1, drive all enables to 0, and remain in HALT until reset.
REQ-030 Outputs SHALL be Moore-decoded from state plus instr; the only Mealy term SHALL be pc_write in EXEC for beq.

Reset
REQ-031 Asserting reset (low) SHALL immediately force state to FETCH and illegal to 0, with all enables 0 while reset is held.
REQ-032 Reset asserted mid-instruction SHALL abort the instruction with no partial reg_write or mem_write.
REQ-033 The first rising edge after reset releases SHALL execute FETCH.

Structure
REQ-034 The opcode/funct constants, the state encoding, and the alu_op and wb_sel codes SHALL live in the shared package mips_pkg.
REQ-035 A combinational sub-module mc_decode SHALL classify instr into instruction class, alu_op, ext_op and dest-select; mc_ctrl SHALL hold the FSM only.

Verification
REQ-036 addu $3,$1,$2 (0x00221821) after reset -> reg_write=1 in cycle 4 only, with num_write=3, wb_sel=00 and alu_op=000.
REQ-037 lw $5,4($0) (0x8C050004) -> cycle 4 mem_write=0; cycle 5 reg_write=1, num_write=5, wb_sel=01.
REQ-038 beq $1,$1,+2 with zero=1 -> pc_write=1 and pc_src=01 in cycle 3; with zero=0 -> pc_write=0 in cycle 3, and the next FETCH occurs in cycle 4.
REQ-039 j (0x08000C00) -> cycle 2 pc_write=1 and pc_src=10, then ir_write=1 in cycle 3.
REQ-040 Opcode 0x3F -> HALT, illegal=1, and no enables for 20 cycles; then pulse reset low -> illegal=0 and FETCH.
REQ-041 Assert reset during the WB cycle of ori -> reg_write=0 immediately, and no write is issued after release.
